// File: rtl/multi_cycle_core_if.sv
// Unified memory port of multi_cycle_core: request/ready handshake with one
// shared address for instruction fetch and data access.
interface multi_cycle_core_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/multi_cycle_core.sv
// Multi-cycle RV32I-subset core (lw/sw, add/sub/and/or/slt, addi/andi/ori/slti, beq).
// Define MULTI_CYCLE_JAL_EN to add jal; otherwise its opcode halts the core.
module multi_cycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NREGS    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    multi_cycle_core_if.master    bus,
    output logic                  retire,
    output logic                  halted
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_HALT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUR   = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t      state_r;
    logic [31:0] pc_r, old_pc_r, ir_r, mdr_r, a_r, b_r, alu_out_r;
    logic [31:0] rf_r [32];
    logic        mem_req_r, mem_we_r, halted_r;
    logic [31:0] mem_addr_r, mem_wdata_r;

    logic [6:0]  opcode_s, funct7_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rs1_s, rs2_s, rd_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_j_s;
    logic [31:0] rs1_val_s, rs2_val_s, mem_ea_s, alu_res_s, fetch_pc_s, rf_wd_s;
    logic        alu_f3_ok_s, r_legal_s, rf_we_s;
    state_t      dispatch_s;

    function automatic logic reg_ok(input logic [4:0] idx);
        return (idx != 5'd0) && ({27'd0, idx} < NREGS);
    endfunction

    function automatic logic [31:0] alu_op(input logic [2:0] f3, input logic sub,
                                           input logic [31:0] x, input logic [31:0] y);
        case (f3)
            3'b000:  return sub ? (x - y) : (x + y);
            3'b111:  return x & y;
            3'b110:  return x | y;
            3'b010:  return {31'd0, ($signed(x) < $signed(y))};
            default: return 32'd0;
        endcase
    endfunction

    assign opcode_s = ir_r[6:0];
    assign rd_s     = ir_r[11:7];
    assign funct3_s = ir_r[14:12];
    assign rs1_s    = ir_r[19:15];
    assign rs2_s    = ir_r[24:20];
    assign funct7_s = ir_r[31:25];
    assign imm_i_s  = {{20{ir_r[31]}}, ir_r[31:20]};
    assign imm_s_s  = {{20{ir_r[31]}}, ir_r[31:25], ir_r[11:7]};
    assign imm_b_s  = {{19{ir_r[31]}}, ir_r[31], ir_r[7], ir_r[30:25], ir_r[11:8], 1'b0};
    assign imm_j_s  = {{11{ir_r[31]}}, ir_r[31], ir_r[19:12], ir_r[20], ir_r[30:21], 1'b0};

    assign rs1_val_s = reg_ok(rs1_s) ? rf_r[rs1_s] : 32'd0;
    assign rs2_val_s = reg_ok(rs2_s) ? rf_r[rs2_s] : 32'd0;

    assign alu_f3_ok_s = (funct3_s == 3'b000) || (funct3_s == 3'b111) ||
                         (funct3_s == 3'b110) || (funct3_s == 3'b010);
    assign r_legal_s   = ((funct7_s == 7'b0000000) && alu_f3_ok_s) ||
                         ((funct7_s == 7'b0100000) && (funct3_s == 3'b000));

    assign mem_ea_s  = a_r + ((opcode_s == OP_STORE) ? imm_s_s : imm_i_s);
    assign alu_res_s = alu_op(funct3_s, (state_r == S_EXECR) && ir_r[30], a_r,
                              (state_r == S_EXECR) ? b_r : imm_i_s);
    // Taken beq redirects to the target computed in DECODE; all others continue at PC.
    assign fetch_pc_s = ((state_r == S_BEQ) && (a_r == b_r)) ? alu_out_r : pc_r;

    assign rf_we_s = ((state_r == S_MEMWB) || (state_r == S_ALUWB)) && reg_ok(rd_s);
    assign rf_wd_s = (state_r == S_MEMWB) ? mdr_r : alu_out_r;

    // Opcode/funct legality and dispatch target for the DECODE state.
    always_comb begin
        dispatch_s = S_HALT;
        case (opcode_s)
            OP_LOAD:   if (funct3_s == 3'b010) dispatch_s = S_MEMADR; else dispatch_s = S_HALT;
            OP_STORE:  if (funct3_s == 3'b010) dispatch_s = S_MEMADR; else dispatch_s = S_HALT;
            OP_ALUR:   if (r_legal_s) dispatch_s = S_EXECR; else dispatch_s = S_HALT;
            OP_ALUI:   if (alu_f3_ok_s) dispatch_s = S_EXECI; else dispatch_s = S_HALT;
            OP_BRANCH: if (funct3_s == 3'b000) dispatch_s = S_BEQ; else dispatch_s = S_HALT;
`ifdef MULTI_CYCLE_JAL_EN
            OP_JAL:    dispatch_s = S_JAL;
`endif
            default:   dispatch_s = S_HALT;
        endcase
    end

    // Register file; x0 and indices beyond NREGS are never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_r[i] <= 32'd0;
        end else if (rf_we_s) begin
            rf_r[rd_s] <= rf_wd_s;
        end
    end

    // Control FSM with datapath registers and registered memory-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_FETCH;
            pc_r        <= RESET_PC;
            old_pc_r    <= 32'd0;
            ir_r        <= 32'd0;
            mdr_r       <= 32'd0;
            a_r         <= 32'd0;
            b_r         <= 32'd0;
            alu_out_r   <= 32'd0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            halted_r    <= 1'b0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (!mem_req_r) begin
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= {pc_r[31:2], 2'b00};
                    end else if (bus.mem_ready) begin
                        ir_r      <= bus.mem_rdata;
                        old_pc_r  <= pc_r;
                        pc_r      <= pc_r + 32'd4;
                        mem_req_r <= 1'b0;
                        state_r   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_r       <= rs1_val_s;
                    b_r       <= rs2_val_s;
                    alu_out_r <= old_pc_r + imm_b_s;
                    state_r   <= dispatch_s;
                    if (dispatch_s == S_HALT) halted_r <= 1'b1;
                end
                S_MEMADR: begin
                    alu_out_r <= mem_ea_s;
                    if (mem_ea_s[1:0] != 2'b00) begin
                        state_r  <= S_HALT;
                        halted_r <= 1'b1;
                    end else begin
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= (opcode_s == OP_STORE);
                        mem_addr_r  <= mem_ea_s;
                        mem_wdata_r <= b_r;
                        state_r     <= (opcode_s == OP_STORE) ? S_MEMWR : S_MEMRD;
                    end
                end
                S_MEMRD: begin
                    if (bus.mem_ready) begin
                        mdr_r     <= bus.mem_rdata;
                        mem_req_r <= 1'b0;
                        state_r   <= S_MEMWB;
                    end
                end
                S_MEMWR: begin
                    if (bus.mem_ready) begin
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= {pc_r[31:2], 2'b00};
                        state_r    <= S_FETCH;
                    end
                end
                S_EXECR, S_EXECI: begin
                    alu_out_r <= alu_res_s;
                    state_r   <= S_ALUWB;
                end
                S_MEMWB, S_ALUWB, S_BEQ: begin
                    pc_r       <= fetch_pc_s;
                    mem_req_r  <= 1'b1;
                    mem_we_r   <= 1'b0;
                    mem_addr_r <= {fetch_pc_s[31:2], 2'b00};
                    state_r    <= S_FETCH;
                end
`ifdef MULTI_CYCLE_JAL_EN
                S_JAL: begin
                    pc_r      <= old_pc_r + imm_j_s;
                    alu_out_r <= old_pc_r + 32'd4;
                    state_r   <= S_ALUWB;
                end
`endif
                S_HALT: begin
                    mem_req_r <= 1'b0;
                    halted_r  <= 1'b1;
                end
                default: begin
                    mem_req_r <= 1'b0;
                    halted_r  <= 1'b1;
                    state_r   <= S_HALT;
                end
            endcase
        end
    end

    // A store retires on its completing edge, which depends on this cycle's mem_ready.
    assign retire = (state_r == S_MEMWB) || (state_r == S_ALUWB) || (state_r == S_BEQ) ||
                    ((state_r == S_MEMWR) && bus.mem_ready);

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign halted        = halted_r;

endmodule

// File: tb/tb_multi_cycle_core.sv
// Self-checking bench for multi_cycle_core: expected bus transactions and
// per-instruction cycle counts are queued as programs are loaded.
module tb_multi_cycle_core;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [6:0]  OPI    = 7'b0010011;
    localparam logic [6:0]  OPL    = 7'b0000011;

    logic clk = 1'b0;
    logic rst;
    logic retire, halted;

    multi_cycle_core_if bus ();

    multi_cycle_core #(.RESET_PC(RST_PC), .NREGS(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .retire (retire),
        .halted (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        exp_q [$];
    int          cpi_q [$];
    logic [31:0] mem [256];
    int          total, bad, cyc, last_ret, n_extra, stall_cnt;
    bit          started, holding;
    logic [31:0] hold_addr, stall_addr;
    logic        stall_we;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic ins(input logic [31:0] pc, input logic [31:0] w, input int cpi);
        txn_t t;
        mem[pc[9:2]] = w;
        t.we = 1'b0; t.addr = pc; t.wdata = 32'd0;
        exp_q.push_back(t);
        if (cpi > 0) cpi_q.push_back(cpi);
    endtask

    task automatic exp_w(input logic [31:0] addr, input logic [31:0] data);
        txn_t t;
        t.we = 1'b1; t.addr = addr; t.wdata = data;
        exp_q.push_back(t);
    endtask

    task automatic exp_r(input logic [31:0] addr);
        txn_t t;
        t.we = 1'b0; t.addr = addr; t.wdata = 32'd0;
        exp_q.push_back(t);
    endtask

    // One clock: memory responds just after the edge, bus is observed at the falling edge.
    task automatic tick();
        txn_t t;
        @(posedge clk);
        #1;
        if (bus.mem_req && (stall_cnt > 0) && (bus.mem_addr == stall_addr) && (bus.mem_we == stall_we)) begin
            bus.mem_ready = 1'b0;
            stall_cnt--;
        end else begin
            bus.mem_ready = 1'b1;
        end
        bus.mem_rdata = mem[bus.mem_addr[9:2]];
        @(negedge clk);
        if (!rst) begin
            cyc++;
            if (!started && bus.mem_req) begin
                started  = 1'b1;
                last_ret = cyc - 1;
            end
            if (bus.mem_req && !bus.mem_ready) begin
                if (holding) check_eq("hold_addr", bus.mem_addr, hold_addr);
                else begin holding = 1'b1; hold_addr = bus.mem_addr; end
            end else if (bus.mem_req) begin
                holding = 1'b0;
                if (exp_q.size() == 0) n_extra++;
                else begin
                    t = exp_q.pop_front();
                    check_eq("txn_we", {31'd0, bus.mem_we}, {31'd0, t.we});
                    check_eq("txn_addr", bus.mem_addr, t.addr);
                    if (t.we) check_eq("txn_wdata", bus.mem_wdata, t.wdata);
                end
                if (bus.mem_we) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
            end
            if (retire) begin
                if (cpi_q.size() == 0) n_extra++;
                else check_eq("cpi", cyc - last_ret, cpi_q.pop_front());
                last_ret = cyc;
            end
            if (halted) check_eq("halt_req", {31'd0, bus.mem_req}, 32'd0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        cpi_q.delete();
        started = 1'b0; holding = 1'b0;
        n_extra = 0; cyc = 0; stall_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        tick();
        tick();
        check_eq("rst_req", {31'd0, bus.mem_req}, 32'd0);
        check_eq("rst_we", {31'd0, bus.mem_we}, 32'd0);
        check_eq("rst_addr", bus.mem_addr, 32'd0);
        check_eq("rst_wdata", bus.mem_wdata, 32'd0);
        check_eq("rst_retire", {31'd0, retire}, 32'd0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
    endtask

    task automatic release_reset();
        rst = 1'b0;
        tick();
        check_eq("req_rise", {31'd0, bus.mem_req}, 32'd1);
        check_eq("first_addr", bus.mem_addr, RST_PC);
        check_eq("first_we", {31'd0, bus.mem_we}, 32'd0);
    endtask

    task automatic run_to_halt(input int max_cycles);
        int n;
        n = 0;
        while (!halted && (n < max_cycles)) begin
            tick();
            n++;
        end
        check_eq("halted", {31'd0, halted}, 32'd1);
        repeat (6) tick();
        check_eq("exp_left", exp_q.size(), 32'd0);
        check_eq("cpi_left", cpi_q.size(), 32'd0);
        check_eq("extra", n_extra, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'd0;
        total = 0;
        bad   = 0;

        // ALU ops, stores, stalled load, x0 write, rd==rs1, branches, misaligned load.
        do_reset();
        ins(32'h100, enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI), 4);
        ins(32'h104, enc_i(12'd7, 5'd0, 3'b000, 5'd2, OPI), 4);
        ins(32'h108, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 4);
        ins(32'h10C, enc_s(12'd8, 5'd3, 5'd0), 4);   exp_w(32'd8, 32'd12);
        ins(32'h110, enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 4);
        ins(32'h114, enc_s(12'd12, 5'd4, 5'd0), 4);  exp_w(32'd12, 32'hFFFF_FFFE);
        ins(32'h118, enc_r(7'h00, 5'd1, 5'd4, 3'b010, 5'd5), 4);
        ins(32'h11C, enc_i(12'hFFF, 5'd1, 3'b010, 5'd6, OPI), 4);
        ins(32'h120, enc_i(12'd3, 5'd2, 3'b111, 5'd7, OPI), 4);
        ins(32'h124, enc_i(12'd8, 5'd1, 3'b110, 5'd8, OPI), 4);
        ins(32'h128, enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd9), 4);
        ins(32'h12C, enc_r(7'h00, 5'd1, 5'd4, 3'b110, 5'd10), 4);
        ins(32'h130, enc_s(12'd16, 5'd5, 5'd0), 4);  exp_w(32'd16, 32'd1);
        ins(32'h134, enc_s(12'd20, 5'd6, 5'd0), 4);  exp_w(32'd20, 32'd0);
        ins(32'h138, enc_s(12'd24, 5'd7, 5'd0), 4);  exp_w(32'd24, 32'd3);
        ins(32'h13C, enc_s(12'd28, 5'd8, 5'd0), 4);  exp_w(32'd28, 32'd13);
        ins(32'h140, enc_s(12'd32, 5'd9, 5'd0), 4);  exp_w(32'd32, 32'd5);
        ins(32'h144, enc_s(12'd36, 5'd10, 5'd0), 4); exp_w(32'd36, 32'hFFFF_FFFF);
        ins(32'h148, enc_i(12'd8, 5'd0, 3'b010, 5'd11, OPL), 8); exp_r(32'd8);
        ins(32'h14C, enc_s(12'd40, 5'd11, 5'd0), 4); exp_w(32'd40, 32'd12);
        ins(32'h150, enc_i(12'd9, 5'd0, 3'b000, 5'd0, OPI), 4);
        ins(32'h154, enc_s(12'd44, 5'd0, 5'd0), 4);  exp_w(32'd44, 32'd0);
        ins(32'h158, enc_i(12'd1, 5'd1, 3'b000, 5'd1, OPI), 4);
        ins(32'h15C, enc_s(12'd48, 5'd1, 5'd0), 4);  exp_w(32'd48, 32'd6);
        ins(32'h160, enc_b(13'd16, 5'd2, 5'd1), 3);
        ins(32'h164, enc_b(13'd12, 5'd2, 5'd2), 3);
        ins(32'h170, enc_b(13'h1FF8, 5'd0, 5'd0), 3);
        ins(32'h168, enc_b(13'd12, 5'd0, 5'd0), 3);
        ins(32'h174, enc_i(12'd2, 5'd0, 3'b010, 5'd5, OPL), 0);
        stall_addr = 32'd8;
        stall_we   = 1'b0;
        stall_cnt  = 3;
        release_reset();
        run_to_halt(400);

        // jal: links and jumps when built in, otherwise halts.
        do_reset();
        ins(32'h100, enc_i(12'd3, 5'd0, 3'b000, 5'd1, OPI), 4);
`ifdef MULTI_CYCLE_JAL_EN
        ins(32'h104, enc_j(21'd16, 5'd1), 4);
        ins(32'h114, enc_s(12'd0, 5'd1, 5'd0), 4); exp_w(32'd0, 32'h0000_0108);
        ins(32'h118, 32'h0000_0000, 0);
`else
        ins(32'h104, enc_j(21'd16, 5'd1), 0);
`endif
        release_reset();
        run_to_halt(200);

        // Reset asserted while a store is stalled: request drops at once, no write lands.
        do_reset();
        mem[1] = 32'hA5A5_A5A5;
        ins(32'h100, enc_i(12'd9, 5'd0, 3'b000, 5'd1, OPI), 4);
        ins(32'h104, enc_s(12'd4, 5'd1, 5'd0), 0);
        stall_addr = 32'd4;
        stall_we   = 1'b1;
        stall_cnt  = 100;
        release_reset();
        n = 0;
        while (!(bus.mem_req && bus.mem_we) && (n < 30)) begin
            tick();
            n++;
        end
        tick();
        check_eq("abort_pending", {31'd0, bus.mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("abort_req", {31'd0, bus.mem_req}, 32'd0);
        check_eq("abort_we", {31'd0, bus.mem_we}, 32'd0);
        check_eq("abort_retire", {31'd0, retire}, 32'd0);
        check_eq("abort_mem", mem[1], 32'hA5A5_A5A5);
        check_eq("abort_exp", exp_q.size(), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
